branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 163 ++++++++++++++++
 tb/tb_branch_resolve.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// RV32I conditional-branch resolution unit: compares operands, computes the target,
// flags mispredictions, and holds one result in a valid/ready output register.

module cmp_32u (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        equal,
  output logic        alarger,
  output logic        blarger
);
  assign equal   = (a == b);
  assign alarger = (a > b);
  assign blarger = (b > a);
endmodule

module cmp_32s (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        equal,
  output logic        alarger,
  output logic        blarger
);
  assign equal   = (a == b);
  assign alarger = ($signed(a) > $signed(b));
  assign blarger = ($signed(b) > $signed(a));
endmodule

module branch_resolve (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic        pred_taken_i,
  input  logic        flush_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        taken_o,
  output logic [31:0] target_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        illegal_o,
  output logic        misalign_o,
  output logic [15:0] br_count_o,
  output logic [15:0] mispred_count_o
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state_q, state_d;

  logic u_equal, u_blarger, u_alarger_unused;
  logic s_blarger, s_equal_unused, s_alarger_unused;

  cmp_32u u_cmp_u (
    .a       (rs1_i),
    .b       (rs2_i),
    .equal   (u_equal),
    .alarger (u_alarger_unused),
    .blarger (u_blarger)
  );

  cmp_32s u_cmp_s (
    .a       (rs1_i),
    .b       (rs2_i),
    .equal   (s_equal_unused),
    .alarger (s_alarger_unused),
    .blarger (s_blarger)
  );

  logic        cond;
  logic        illegal;
  logic        taken;
  logic        misalign;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] seq_pc;
  logic [31:0] redirect_pc;
  logic        capture;
  logic        consume;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3_i)
      3'b000:  cond = u_equal;
      3'b001:  cond = ~u_equal;
      3'b100:  cond = s_blarger;
      3'b101:  cond = ~s_blarger;
      3'b110:  cond = u_blarger;
      3'b111:  cond = ~u_blarger;
      default: illegal = 1'b1;
    endcase
  end

  assign target      = pc_i + imm_i;
  assign seq_pc      = pc_i + 32'd4;
  assign taken       = cond & ~illegal;
  assign misalign    = taken & (target[1:0] != 2'b00);
  assign redirect    = ~illegal & ~misalign & (taken != pred_taken_i);
  assign redirect_pc = redirect ? (taken ? target : seq_pc) : 32'd0;

  assign valid_o = (state_q == FULL);
  assign ready_o = ~valid_o | ready_i;
  assign capture = valid_i & ready_o & ~flush_i;
  assign consume = valid_o & ready_i & ~flush_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (capture) state_d = FULL;
      FULL:    if (ready_i && !capture) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    // A kill discards both the held result and anything presented alongside it.
    if (flush_i) state_d = EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      taken_o       <= 1'b0;
      target_o      <= 32'd0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= 32'd0;
      illegal_o     <= 1'b0;
      misalign_o    <= 1'b0;
    end else if (capture) begin
      taken_o       <= taken;
      target_o      <= target;
      redirect_o    <= redirect;
      redirect_pc_o <= redirect_pc;
      illegal_o     <= illegal;
      misalign_o    <= misalign;
    end
  end

  // Statistics count the result as it leaves, so they reflect the held fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_count_o      <= 16'd0;
      mispred_count_o <= 16'd0;
    end else if (consume && !illegal_o) begin
      if (br_count_o != 16'hFFFF)
        br_count_o <= br_count_o + 16'd1;
      if ((redirect_o || misalign_o) && (mispred_count_o != 16'hFFFF))
        mispred_count_o <= mispred_count_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: vector table through a scoreboard,
// plus stall, flush, reset and counter-saturation sequences.
`timescale 1ns/1ps

module tb_branch_resolve;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i, rs2_i, pc_i, imm_i;
  logic        pred_taken_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic        taken_o;
  logic [31:0] target_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        illegal_o;
  logic        misalign_o;
  logic [15:0] br_count_o;
  logic [15:0] mispred_count_o;

  always #5 clk_i = ~clk_i;

  branch_resolve dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .funct3_i        (funct3_i),
    .rs1_i           (rs1_i),
    .rs2_i           (rs2_i),
    .pc_i            (pc_i),
    .imm_i           (imm_i),
    .pred_taken_i    (pred_taken_i),
    .flush_i         (flush_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .taken_o         (taken_o),
    .target_o        (target_o),
    .redirect_o      (redirect_o),
    .redirect_pc_o   (redirect_pc_o),
    .illegal_o       (illegal_o),
    .misalign_o      (misalign_o),
    .br_count_o      (br_count_o),
    .mispred_count_o (mispred_count_o)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, imm;
    logic        pred;
    logic        t;
    logic [31:0] tgt;
    logic        r;
    logic [31:0] rpc;
    logic        ill, mis;
  } vec_t;

  vec_t        tbl [11];
  logic [67:0] sb [$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] br_exp  = 16'd0;
  logic [15:0] mis_exp = 16'd0;

  function automatic vec_t mk(logic [2:0] f3, logic [31:0] rs1, logic [31:0] rs2,
                              logic [31:0] pc, logic [31:0] imm, logic pred,
                              logic t, logic [31:0] tgt, logic r, logic [31:0] rpc,
                              logic ill, logic mis);
    vec_t v;
    v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm; v.pred = pred;
    v.t = t; v.tgt = tgt; v.r = r; v.rpc = rpc; v.ill = ill; v.mis = mis;
    return v;
  endfunction

  function automatic logic [67:0] exp_of(vec_t v);
    return {v.t, v.tgt, v.r, v.rpc, v.ill, v.mis};
  endfunction

  function automatic logic [67:0] act();
    return {taken_o, target_o, redirect_o, redirect_pc_o, illegal_o, misalign_o};
  endfunction

  task automatic check(input string name, input logic [67:0] got, input logic [67:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input vec_t v);
    valid_i      = 1'b1;
    funct3_i     = v.f3;
    rs1_i        = v.rs1;
    rs2_i        = v.rs2;
    pc_i         = v.pc;
    imm_i        = v.imm;
    pred_taken_i = v.pred;
  endtask

  task automatic pop_check(input string name);
    check({name, " valid"}, 68'(valid_o), 68'(1));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got result %h expected none queued", name, act());
    end else begin
      check(name, act(), sb.pop_front());
    end
  endtask

  // Reference counter model driven by the table's expected flags.
  task automatic account(input vec_t v);
    if (!v.ill) begin
      if (br_exp != 16'hFFFF) br_exp++;
      if ((v.r || v.mis) && mis_exp != 16'hFFFF) mis_exp++;
    end
  endtask

  task automatic check_counts(input string name);
    check({name, " br_count"}, 68'(br_count_o), 68'(br_exp));
    check({name, " mispred_count"}, 68'(mispred_count_o), 68'(mis_exp));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  initial begin
    //            f3      rs1           rs2           pc            imm           pred  t  tgt           r  rpc           ill mis
    tbl[0]  = mk(3'b100, 32'hFFFFFFFF, 32'h1,        32'h100,      32'h20,       1'b0, 1, 32'h120,      1, 32'h120,      0, 0);
    tbl[1]  = mk(3'b110, 32'hFFFFFFFF, 32'h1,        32'h100,      32'h20,       1'b1, 0, 32'h120,      1, 32'h104,      0, 0);
    tbl[2]  = mk(3'b000, 32'h5,        32'h5,        32'hFFFFFFF0, 32'h20,       1'b1, 1, 32'h10,       0, 32'h0,        0, 0);
    tbl[3]  = mk(3'b000, 32'h5,        32'h5,        32'hFFFFFFF0, 32'h22,       1'b1, 1, 32'h12,       0, 32'h0,        0, 1);
    tbl[4]  = mk(3'b001, 32'h5,        32'h5,        32'h200,      32'h40,       1'b0, 0, 32'h240,      0, 32'h0,        0, 0);
    tbl[5]  = mk(3'b101, 32'h1,        32'hFFFFFFFF, 32'h300,      32'hFFFFFFF0, 1'b0, 1, 32'h2F0,      1, 32'h2F0,      0, 0);
    tbl[6]  = mk(3'b111, 32'h1,        32'hFFFFFFFF, 32'h400,      32'h8,        1'b0, 0, 32'h408,      0, 32'h0,        0, 0);
    tbl[7]  = mk(3'b010, 32'h0,        32'h0,        32'h500,      32'h4,        1'b0, 0, 32'h504,      0, 32'h0,        1, 0);
    tbl[8]  = mk(3'b011, 32'h3,        32'h3,        32'h600,      32'h8,        1'b1, 0, 32'h608,      0, 32'h0,        1, 0);
    tbl[9]  = mk(3'b100, 32'h7,        32'h7,        32'hFFFFFFFC, 32'h10,       1'b1, 0, 32'hC,        1, 32'h0,        0, 0);
    tbl[10] = mk(3'b110, 32'h1,        32'h2,        32'h700,      32'h6,        1'b0, 1, 32'h706,      0, 32'h0,        0, 1);

    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    funct3_i = 3'b000; rs1_i = '0; rs2_i = '0; pc_i = '0; imm_i = '0; pred_taken_i = 1'b0;
    step();
    step();
    check("reset valid_o", 68'(valid_o), 68'(0));
    check("reset fields", act(), 68'(0));
    check_counts("reset");
    rst_i = 1'b0;
    #1;
    check("ready after reset", 68'(ready_o), 68'(1));

    // Vector table: one branch at a time, drained the cycle after it appears.
    ready_i = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i]);
      sb.push_back(exp_of(tbl[i]));
      step();
      valid_i = 1'b0;
      pop_check($sformatf("vec%0d", i));
      step();
      account(tbl[i]);
    end
    check("table drained valid_o", 68'(valid_o), 68'(0));
    check_counts("table");

    // Back-pressure: held result stays put for three cycles, then swaps in one edge.
    drive(tbl[0]);
    sb.push_back(exp_of(tbl[0]));
    step();
    ready_i = 1'b0;
    drive(tbl[4]);
    #1;
    check("stall ready_o", 68'(ready_o), 68'(0));
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall hold %0d", c), act(), sb[0]);
      check($sformatf("stall valid %0d", c), 68'(valid_o), 68'(1));
      check($sformatf("stall ready %0d", c), 68'(ready_o), 68'(0));
    end
    check_counts("stall before release");
    pop_check("stall A");
    account(tbl[0]);
    ready_i = 1'b1;
    sb.push_back(exp_of(tbl[4]));
    step();
    pop_check("stall B");
    check_counts("stall released");
    valid_i = 1'b0;
    step();
    account(tbl[4]);
    check_counts("stall drained");

    // Flush with a held result and a new branch presented in the same cycle.
    drive(tbl[0]);
    sb.push_back(exp_of(tbl[0]));
    step();
    flush_i = 1'b1;
    drive(tbl[1]);
    ready_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    sb.delete();
    check("flush valid_o", 68'(valid_o), 68'(0));
    check("flush ready_o", 68'(ready_o), 68'(1));
    check_counts("flush");

    drive(tbl[7]);
    sb.push_back(exp_of(tbl[7]));
    step();
    valid_i = 1'b0;
    pop_check("illegal 010");
    step();
    check_counts("illegal not counted");

    // Reset while a result is held discards it and clears statistics.
    drive(tbl[0]);
    sb.push_back(exp_of(tbl[0]));
    step();
    valid_i = 1'b0;
    ready_i = 1'b0;
    rst_i   = 1'b1;
    step();
    rst_i = 1'b0;
    sb.delete();
    br_exp  = 16'd0;
    mis_exp = 16'd0;
    check("reset mid-FULL valid_o", 68'(valid_o), 68'(0));
    check("reset mid-FULL fields", act(), 68'(0));
    check_counts("reset mid-FULL");
    #1;
    check("reset mid-FULL ready_o", 68'(ready_o), 68'(1));

    // Saturation: 65535 handshakes of a correctly predicted branch, then one more.
    ready_i = 1'b1;
    drive(tbl[4]);
    repeat (65535) step();
    valid_i = 1'b0;
    step();
    br_exp = 16'hFFFF;
    check_counts("at saturation");
    drive(tbl[0]);
    sb.push_back(exp_of(tbl[0]));
    step();
    valid_i = 1'b0;
    pop_check("post-saturation");
    step();
    account(tbl[0]);
    check_counts("past saturation");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
